regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources.
//  Port A is the main pipeline writeback and has priority. Port B is the multi-cycle unit or load return.
//  Registers the winning write onto RF_WRITE/RF_INADDRESS/RF_IN.
//  Keeps a busy scoreboard so issue logic can stall on registers still waiting for a port-B result.
// PARAMETERS
//  DATA_W      32  write data width
//  ADDR_W      5   register address width (2**ADDR_W registers)
//  STARVE_MAX  4   consecutive port-B losses before B is force-granted one cycle (>=1)
// PORTS
//  CLK           in   1       clock; all state updates on posedge
//  RESET         in   1       synchronous, active-low reset
//  A_VALID       in   1       port A write request
//  A_ADDR        in   ADDR_W  port A destination register
//  A_DATA        in   DATA_W  port A write data
//  A_READY       out  1       port A accepted this cycle
//  B_VALID       in   1       port B write request
//  B_ADDR        in   ADDR_W  port B destination register
//  B_DATA        in   DATA_W  port B write data
//  B_READY       out  1       port B accepted this cycle
//  SB_SET        in   1       issue marks SB_SET_ADDR as pending a port-B result
//  SB_SET_ADDR   in   ADDR_W  register to mark busy
//  SB_BUSY       out  2**ADDR_W  busy bitmap; bit 0 always 0
//  RF_WRITE      out  1       register file write enable
//  RF_INADDRESS  out  ADDR_W  register file write address
//  RF_IN         out  DATA_W  register file write data
// BEHAVIOUR
//  - Reset (RESET==0 at posedge):
//      RF_WRITE=0, RF_INADDRESS=0, RF_IN=0, SB_BUSY=0, starve_cnt=0, state=A_PRI.
//      A_READY and B_READY are 0 combinationally while RESET==0.
//  - Reset mid-operation: any registered write not yet committed is dropped.
//      RF_WRITE is 0 from the reset edge onward. In-flight requests are not replayed.
//  - Handshake: a transfer occurs at a posedge where VALID&&READY.
//      Once VALID is asserted, the requester holds ADDR/DATA stable until the transfer.
//  - READY is combinational from state and the other port's VALID only, never from the port's own VALID:
//      A_READY = RESET && !(state==B_FORCE && B_VALID)
//      B_READY = RESET && (!A_VALID || state==B_FORCE)
//  - At most one transfer per cycle. Both ports never see READY=1 together while both are VALID.
//  - Latency: 1 cycle. A transfer at edge N drives RF_* during cycle N..N+1, and the RF writes at edge N+1.
//      With no transfer, RF_WRITE=0 and RF_INADDRESS/RF_IN hold their last values.
//  - x0 writes: the handshake completes normally, but RF_WRITE stays 0 (write suppressed).
//  - FSM states:
//      A_PRI: A wins any conflict. Each edge with A_VALID&&B_VALID&&A transfer increments starve_cnt.
//        Any B transfer, or B_VALID=0, clears starve_cnt to 0.
//        When starve_cnt reaches STARVE_MAX-1 on a losing edge -> B_FORCE.
//      B_FORCE: B wins for exactly one cycle if B_VALID. Next state A_PRI, starve_cnt=0.
//        If B_VALID has dropped, A may transfer and the state returns to A_PRI.
//  - Same-address ordering between A and B is the issue logic's job. This block applies writes in grant order.
//  - Scoreboard:
//      SB_SET with SB_SET_ADDR!=0 sets the bit at the edge.
//      A port-B transfer clears bit B_ADDR at the same edge.
//      Set and clear of the same bit on the same edge: set wins (bit stays 1).
//      Port-A transfers never touch SB_BUSY. SB_SET to address 0 is ignored.
// TESTING
//  1 RESET=0 for 2 cycles with A_VALID=B_VALID=1
//      -> A_READY=B_READY=0, RF_WRITE=0, SB_BUSY=0; after RESET=1, A is granted first.
//  2 A_VALID, A_ADDR=3, A_DATA=0x5F, B idle
//      -> A_READY=1 same cycle; next cycle RF_WRITE=1, RF_INADDRESS=3, RF_IN=0x5F; then RF_WRITE=0.
//  3 A and B both held VALID (A_ADDR=1, B_ADDR=2), STARVE_MAX=4
//      -> grants A,A,A,A,B repeating; no cycle with two READY transfers.
//  4 A_ADDR=0, A_DATA=0xFF
//      -> A_READY=1, RF_WRITE stays 0 the next cycle.
//  5 SB_SET addr 7 -> SB_BUSY[7]=1 next cycle; B transfer to addr 7 -> bit clears.
//      B transfer to 7 plus SB_SET 7 on the same edge -> bit stays 1.
//  6 B transfer registered, RESET=0 on the following edge
//      -> RF_WRITE=0 from that edge, SB_BUSY=0, starve_cnt=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file's single write port, with
// anti-starvation for the secondary port and a pending-result busy scoreboard.
//
// state   | meaning
// A_PRI   | port A wins conflicts; starve_cnt counts consecutive B losses
// B_FORCE | port B is guaranteed the grant for one cycle if it is still valid
module regfile_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   A_VALID,
   input  logic [ADDR_W-1:0]      A_ADDR,
   input  logic [DATA_W-1:0]      A_DATA,
   output logic                   A_READY,
   input  logic                   B_VALID,
   input  logic [ADDR_W-1:0]      B_ADDR,
   input  logic [DATA_W-1:0]      B_DATA,
   output logic                   B_READY,
   input  logic                   SB_SET,
   input  logic [ADDR_W-1:0]      SB_SET_ADDR,
   output logic [2**ADDR_W-1:0]   SB_BUSY,
   output logic                   RF_WRITE,
   output logic [ADDR_W-1:0]      RF_INADDRESS,
   output logic [DATA_W-1:0]      RF_IN
);

   localparam int NREG  = 2**ADDR_W;
   localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

   localparam logic [0:0] A_PRI   = 1'b0;
   localparam logic [0:0] B_FORCE = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              rf_write_q, rf_write_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic              a_xfer, b_xfer;

   // Readies never depend on the port's own VALID, so requesters see no comb loop.
   assign A_READY = RESET && !(state_q == B_FORCE && B_VALID);
   assign B_READY = RESET && (!A_VALID || state_q == B_FORCE);
   assign a_xfer  = A_VALID && A_READY;
   assign b_xfer  = B_VALID && B_READY;

   always_comb begin
      state_d      = A_PRI;
      starve_cnt_d = '0;
      if (state_q == A_PRI && a_xfer && B_VALID) begin
         if (starve_cnt_q == CNT_LAST)
            state_d = B_FORCE;
         else
            starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      rf_write_d = 1'b0;
      rf_addr_d  = rf_addr_q;
      rf_data_d  = rf_data_q;
      if (a_xfer) begin
         rf_write_d = (A_ADDR != '0);
         rf_addr_d  = A_ADDR;
         rf_data_d  = A_DATA;
      end else if (b_xfer) begin
         rf_write_d = (B_ADDR != '0);
         rf_addr_d  = B_ADDR;
         rf_data_d  = B_DATA;
      end
   end

   // Clear before set so a same-edge set of the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (b_xfer)
         busy_d[B_ADDR] = 1'b0;
      if (SB_SET && SB_SET_ADDR != '0)
         busy_d[SB_SET_ADDR] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q      <= A_PRI;
         starve_cnt_q <= '0;
         busy_q       <= '0;
         rf_write_q   <= 1'b0;
         rf_addr_q    <= '0;
         rf_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         busy_q       <= busy_d;
         rf_write_q   <= rf_write_d;
         rf_addr_q    <= rf_addr_d;
         rf_data_q    <= rf_data_d;
      end
   end

   assign SB_BUSY      = busy_q;
   assign RF_WRITE     = rf_write_q;
   assign RF_INADDRESS = rf_addr_q;
   assign RF_IN        = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single writes, starvation
// rotation, x0 suppression, scoreboard set/clear, and reset mid-operation.
module tb_regfile_wb_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        A_VALID, B_VALID, SB_SET;
   logic [4:0]  A_ADDR, B_ADDR, SB_SET_ADDR;
   logic [31:0] A_DATA, B_DATA;
   logic        A_READY, B_READY, RF_WRITE;
   logic [31:0] SB_BUSY;
   logic [4:0]  RF_INADDRESS;
   logic [31:0] RF_IN;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
      .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
      .SB_SET(SB_SET), .SB_SET_ADDR(SB_SET_ADDR), .SB_BUSY(SB_BUSY),
      .RF_WRITE(RF_WRITE), .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN)
   );

   task automatic edge_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b0; SB_SET = 1'b0; SB_SET_ADDR = '0;
      A_VALID = 1'b1; A_ADDR = 5'd1; A_DATA = 32'h11;
      B_VALID = 1'b1; B_ADDR = 5'd2; B_DATA = 32'h22;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         checks++;
         if (A_READY !== 1'b0 || B_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: A_READY=%b B_READY=%b required 0/0", A_READY, B_READY);
         end
         edge_step();
         checks++;
         if (RF_WRITE !== 1'b0 || SB_BUSY !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: RF_WRITE=%b SB_BUSY=%h required 0/0", RF_WRITE, SB_BUSY);
         end
      end
      RESET = 1'b1;
      @(negedge CLK);
      checks++;
      if (A_READY !== 1'b1 || B_READY !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_grant: A_READY=%b B_READY=%b required 1/0", A_READY, B_READY);
      end
      edge_step();
      checks++;
      if (RF_WRITE !== 1'b1 || RF_INADDRESS !== 5'd1 || RF_IN !== 32'h11) begin
         errors++;
         $display("FAIL reset_first_write: we=%b addr=%0d data=%h required 1/1/11", RF_WRITE, RF_INADDRESS, RF_IN);
      end
      A_VALID = 1'b0; B_VALID = 1'b0;
      edge_step();
   endtask

   task automatic test_single_a();
      A_VALID = 1'b1; A_ADDR = 5'd3; A_DATA = 32'h5F;
      @(negedge CLK);
      checks++;
      if (A_READY !== 1'b1) begin
         errors++;
         $display("FAIL single_a_ready: A_READY=%b required 1", A_READY);
      end
      edge_step();
      checks++;
      if (RF_WRITE !== 1'b1 || RF_INADDRESS !== 5'd3 || RF_IN !== 32'h5F) begin
         errors++;
         $display("FAIL single_a_write: we=%b addr=%0d data=%h required 1/3/5f", RF_WRITE, RF_INADDRESS, RF_IN);
      end
      A_VALID = 1'b0;
      edge_step();
      checks++;
      if (RF_WRITE !== 1'b0 || RF_INADDRESS !== 5'd3 || RF_IN !== 32'h5F) begin
         errors++;
         $display("FAIL single_a_idle: we=%b addr=%0d data=%h required 0/3/5f", RF_WRITE, RF_INADDRESS, RF_IN);
      end
   endtask

   task automatic test_starvation();
      logic exp_a;
      A_VALID = 1'b1; A_ADDR = 5'd1; A_DATA = 32'hA1;
      B_VALID = 1'b1; B_ADDR = 5'd2; B_DATA = 32'hB2;
      for (int i = 0; i < 10; i++) begin
         exp_a = ((i % 5) != 4);
         @(negedge CLK);
         checks++;
         if (A_READY !== exp_a || B_READY !== !exp_a) begin
            errors++;
            $display("FAIL starve_grant[%0d]: A_READY=%b B_READY=%b required %b/%b", i, A_READY, B_READY, exp_a, !exp_a);
         end
         edge_step();
         checks++;
         if (RF_WRITE !== 1'b1 || RF_INADDRESS !== (exp_a ? 5'd1 : 5'd2) || RF_IN !== (exp_a ? 32'hA1 : 32'hB2)) begin
            errors++;
            $display("FAIL starve_write[%0d]: we=%b addr=%0d data=%h required 1/%0d", i, RF_WRITE, RF_INADDRESS, RF_IN, exp_a ? 1 : 2);
         end
      end
      A_VALID = 1'b0; B_VALID = 1'b0;
      edge_step();
   endtask

   task automatic test_x0_write();
      A_VALID = 1'b1; A_ADDR = 5'd0; A_DATA = 32'hFF;
      @(negedge CLK);
      checks++;
      if (A_READY !== 1'b1) begin
         errors++;
         $display("FAIL x0_ready: A_READY=%b required 1", A_READY);
      end
      edge_step();
      checks++;
      if (RF_WRITE !== 1'b0) begin
         errors++;
         $display("FAIL x0_suppress: RF_WRITE=%b required 0", RF_WRITE);
      end
      A_VALID = 1'b0;
      edge_step();
   endtask

   task automatic test_scoreboard();
      SB_SET = 1'b1; SB_SET_ADDR = 5'd7;
      edge_step();
      checks++;
      if (SB_BUSY !== 32'h0000_0080) begin
         errors++;
         $display("FAIL sb_set: SB_BUSY=%h required 00000080", SB_BUSY);
      end
      SB_SET_ADDR = 5'd0;
      edge_step();
      checks++;
      if (SB_BUSY !== 32'h0000_0080) begin
         errors++;
         $display("FAIL sb_set_x0: SB_BUSY=%h required 00000080", SB_BUSY);
      end
      SB_SET = 1'b0;
      A_VALID = 1'b1; A_ADDR = 5'd7; A_DATA = 32'h77;
      edge_step();
      checks++;
      if (SB_BUSY !== 32'h0000_0080) begin
         errors++;
         $display("FAIL sb_a_no_clear: SB_BUSY=%h required 00000080", SB_BUSY);
      end
      A_VALID = 1'b0;
      B_VALID = 1'b1; B_ADDR = 5'd7; B_DATA = 32'hB7;
      edge_step();
      checks++;
      if (SB_BUSY !== 32'h0 || RF_WRITE !== 1'b1 || RF_INADDRESS !== 5'd7 || RF_IN !== 32'hB7) begin
         errors++;
         $display("FAIL sb_b_clear: SB_BUSY=%h we=%b addr=%0d data=%h required 0/1/7/b7", SB_BUSY, RF_WRITE, RF_INADDRESS, RF_IN);
      end
      B_VALID = 1'b0; SB_SET = 1'b1; SB_SET_ADDR = 5'd7;
      edge_step();
      B_VALID = 1'b1; B_DATA = 32'hC7;
      edge_step();
      checks++;
      if (SB_BUSY !== 32'h0000_0080) begin
         errors++;
         $display("FAIL sb_set_wins: SB_BUSY=%h required 00000080", SB_BUSY);
      end
      B_VALID = 1'b0; SB_SET = 1'b0;
      edge_step();
   endtask

   task automatic test_reset_mid_op();
      int a_grants;
      bit seen_b;
      B_VALID = 1'b1; B_ADDR = 5'd5; B_DATA = 32'h55;
      SB_SET = 1'b1; SB_SET_ADDR = 5'd9;
      edge_step();
      checks++;
      if (RF_WRITE !== 1'b1 || RF_INADDRESS !== 5'd5) begin
         errors++;
         $display("FAIL midrst_pre: we=%b addr=%0d required 1/5", RF_WRITE, RF_INADDRESS);
      end
      B_VALID = 1'b0; SB_SET = 1'b0; RESET = 1'b0;
      edge_step();
      checks++;
      if (RF_WRITE !== 1'b0 || SB_BUSY !== 32'h0 || RF_INADDRESS !== 5'd0 || RF_IN !== 32'h0) begin
         errors++;
         $display("FAIL midrst_drop: we=%b busy=%h addr=%0d data=%h required all 0", RF_WRITE, SB_BUSY, RF_INADDRESS, RF_IN);
      end
      RESET = 1'b1;
      A_VALID = 1'b1; A_ADDR = 5'd1; A_DATA = 32'hA1;
      B_VALID = 1'b1; B_ADDR = 5'd2; B_DATA = 32'hB2;
      repeat (3) edge_step();
      RESET = 1'b0;
      edge_step();
      RESET = 1'b1;
      a_grants = 0;
      seen_b = 1'b0;
      for (int i = 0; i < 10 && !seen_b; i++) begin
         @(negedge CLK);
         if (B_READY === 1'b1) seen_b = 1'b1;
         else if (A_READY === 1'b1) a_grants++;
         edge_step();
      end
      checks++;
      if (!seen_b || a_grants != 4) begin
         errors++;
         $display("FAIL midrst_starve_cnt: A grants before B=%0d (B seen=%b) required 4", a_grants, seen_b);
      end
      A_VALID = 1'b0; B_VALID = 1'b0;
      edge_step();
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_starvation();
      test_x0_write();
      test_scoreboard();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
